coin_acceptor: RTL and testbench
================================

Name: coin_acceptor

Overview:
- Front-end coin/note validator feeding the vending machine's money input (`i_money` / `i_money_valid`).
- Classifies raw sensor values (cents) into 4-bit denomination codes and buffers them in a small FIFO.
- Forwards codes one pulse at a time, paced and gated by `i_accept_en`, because the vending machine drops money pulses outside its money-entry phase.
- On `i_flush`, returns all buffered coins to the customer as return codes.

Parameters:
- FIFO_DEPTH, 8, entries in coin FIFO (power of two, >=2)
- GAP_CYCLES, 2, idle cycles forced after each o_money_valid pulse (0 allowed)

Ports:
- i_clk  in  1  system clock
- i_rst  in  1  reset; one clock; reset is asynchronous and active-high
- i_coin_value  in  17  sensed value in cents (1..50000)
- i_coin_strobe  in  1  one-cycle pulse, i_coin_value valid
- i_accept_en  in  1  downstream accepts money this cycle
- i_flush  in  1  level; return all buffered coins
- o_money  out  4  denomination code to vending machine
- o_money_valid  out  1  one-cycle pulse, o_money valid
- o_coin_reject  out  1  one-cycle pulse, strobed coin rejected
- o_return_code  out  4  code of coin being returned
- o_return_valid  out  1  one-cycle pulse, o_return_code valid
- o_fifo_level  out  $clog2(FIFO_DEPTH)+1  current occupancy
- o_fifo_empty  out  1  occupancy == 0
- o_fifo_full  out  1  occupancy == FIFO_DEPTH

Behaviour:
- **Reset (async, i_rst=1):**
  - All outputs 0, except o_fifo_empty=1.
  - FIFO pointers cleared; FSM goes to IDLE; gap counter cleared.
  - Reset mid-transfer discards all buffered coins; no pulses are emitted.
- **Classification (combinational on strobe cycle):**
  - Values map to codes: 50000→1, 20000→2, 10000→3, 5000→4, 2000→5, 1000→6, 500→7, 200→8, 100→9, 50→10, 25→11, 10→12, 5→13, 2→14, 1→15.
  - Any other value is invalid.
- **Push rule:** on strobe, if the code is valid, the FIFO is not full and the FSM is not in FLUSH, write the code at the clock edge. Otherwise o_coin_reject=1 in the next cycle.
  - Full is evaluated before a same-cycle pop, so a strobe while full is rejected even if a pop occurs.
  - Push and pop in the same cycle leave the level unchanged.
- **FSM states:** IDLE, GAP, FLUSH.
  - IDLE, i_flush=1 and not empty → FLUSH. Flush has priority over forwarding.
  - IDLE, i_accept_en=1, i_flush=0, not empty → register o_money=head and o_money_valid=1 for exactly one cycle, pop. Go to GAP if GAP_CYCLES>0, else stay in IDLE (back-to-back pulses allowed).
  - GAP: count GAP_CYCLES cycles, then go to IDLE. i_flush and i_accept_en are ignored while in GAP.
  - FLUSH: each cycle, register o_return_code=head and o_return_valid=1, then pop.
    - After the pop that empties the FIFO, go to IDLE.
    - Deasserting i_flush mid-flush does not abort the flush.
    - Strobes during FLUSH are rejected.
- **Latency:** strobe in cycle N (FIFO empty, IDLE, accept_en=1) → o_money_valid in cycle N+2.
- o_money and o_return_code are 0 whenever their valid signal is 0.
- o_money_valid and o_return_valid are never high in the same cycle.
- Level outputs are registered and reflect post-edge occupancy.
- The FIFO wraps modulo FIFO_DEPTH, using an extra pointer bit for the full/empty distinction.

Optional Feature:
- Macro COIN_ACCEPTOR_TOTAL_EN.
- **With the macro:**
  - Adds ports `i_total_clr` (in, 1) and `o_total` (out, 21, cents).
  - o_total increments by the coin value on every o_money_valid cycle; returned coins are not counted.
  - o_total resets to 0. i_total_clr clears it synchronously, with priority over a same-cycle add.
  - Saturates at 2^21-1.
- **Without the macro:** both ports and the accumulator are absent.

Decomposition:
- Package vm_pkg holds:
  - denomination code constants;
  - value constants;
  - typedef `denom_code_t` (logic [3:0]);
  - a function `value_to_code()` returning 0 for invalid values.
- The vending machine should migrate to vm_pkg later.
- Sub-module coin_fifo: parameterised synchronous FIFO (push, pop, data, level, full, empty); coin_acceptor instantiates it.

Test Plan:
1. Reset, accept_en=1, strobe value 100 at cycle N → o_money=9, o_money_valid=1 in cycle N+2 only; level returns to 0.
2. Accept_en=0, strobe 500, 25, 1 → level=3, no pulses. Raise accept_en → codes 7, 11, 15 pulsed, each separated by exactly 2 idle cycles (GAP_CYCLES=2).
3. Strobe value 300 → o_coin_reject pulse one cycle later, level unchanged. Fill 8 coins with accept_en=0, strobe a 9th → reject, level=8, o_fifo_full=1.
4. Buffer codes 4, 6, 8 with accept_en=0, assert i_flush for one cycle → o_return_valid on 3 consecutive cycles with codes 4, 6, 8, no o_money_valid. Strobe during flush → rejected.
5. Assert i_rst while level=5 and a GAP is in progress → all outputs 0 immediately (asynchronously), o_fifo_empty=1; after release, no stale coin pulses.
6. With COIN_ACCEPTOR_TOTAL_EN: forward 50000 + 25 → o_total=50025. Pulse i_total_clr in the same cycle as a forwarded 100 → o_total=0.

Source files
------------

// File: rtl/vm_pkg.sv
// Vending-machine shared types: denomination codes, values and
// the value<->code mapping used by the coin front end.
package vm_pkg;

  typedef logic [3:0] denom_code_t;

  localparam denom_code_t CODE_NONE  = 4'd0;
  localparam denom_code_t CODE_50000 = 4'd1;
  localparam denom_code_t CODE_20000 = 4'd2;
  localparam denom_code_t CODE_10000 = 4'd3;
  localparam denom_code_t CODE_5000  = 4'd4;
  localparam denom_code_t CODE_2000  = 4'd5;
  localparam denom_code_t CODE_1000  = 4'd6;
  localparam denom_code_t CODE_500   = 4'd7;
  localparam denom_code_t CODE_200   = 4'd8;
  localparam denom_code_t CODE_100   = 4'd9;
  localparam denom_code_t CODE_50    = 4'd10;
  localparam denom_code_t CODE_25    = 4'd11;
  localparam denom_code_t CODE_10    = 4'd12;
  localparam denom_code_t CODE_5     = 4'd13;
  localparam denom_code_t CODE_2     = 4'd14;
  localparam denom_code_t CODE_1     = 4'd15;

  localparam logic [16:0] VAL_50000 = 17'd50000;
  localparam logic [16:0] VAL_20000 = 17'd20000;
  localparam logic [16:0] VAL_10000 = 17'd10000;
  localparam logic [16:0] VAL_5000  = 17'd5000;
  localparam logic [16:0] VAL_2000  = 17'd2000;
  localparam logic [16:0] VAL_1000  = 17'd1000;
  localparam logic [16:0] VAL_500   = 17'd500;
  localparam logic [16:0] VAL_200   = 17'd200;
  localparam logic [16:0] VAL_100   = 17'd100;
  localparam logic [16:0] VAL_50    = 17'd50;
  localparam logic [16:0] VAL_25    = 17'd25;
  localparam logic [16:0] VAL_10    = 17'd10;
  localparam logic [16:0] VAL_5     = 17'd5;
  localparam logic [16:0] VAL_2     = 17'd2;
  localparam logic [16:0] VAL_1     = 17'd1;

  function automatic denom_code_t value_to_code(
    input logic [16:0] v
  );
    case (v)
      VAL_50000: return CODE_50000;
      VAL_20000: return CODE_20000;
      VAL_10000: return CODE_10000;
      VAL_5000:  return CODE_5000;
      VAL_2000:  return CODE_2000;
      VAL_1000:  return CODE_1000;
      VAL_500:   return CODE_500;
      VAL_200:   return CODE_200;
      VAL_100:   return CODE_100;
      VAL_50:    return CODE_50;
      VAL_25:    return CODE_25;
      VAL_10:    return CODE_10;
      VAL_5:     return CODE_5;
      VAL_2:     return CODE_2;
      VAL_1:     return CODE_1;
      default:   return CODE_NONE;
    endcase
  endfunction

  function automatic logic [16:0] code_to_value(
    input denom_code_t c
  );
    case (c)
      CODE_50000: return VAL_50000;
      CODE_20000: return VAL_20000;
      CODE_10000: return VAL_10000;
      CODE_5000:  return VAL_5000;
      CODE_2000:  return VAL_2000;
      CODE_1000:  return VAL_1000;
      CODE_500:   return VAL_500;
      CODE_200:   return VAL_200;
      CODE_100:   return VAL_100;
      CODE_50:    return VAL_50;
      CODE_25:    return VAL_25;
      CODE_10:    return VAL_10;
      CODE_5:     return VAL_5;
      CODE_2:     return VAL_2;
      CODE_1:     return VAL_1;
      default:    return 17'd0;
    endcase
  endfunction

endpackage

// File: rtl/coin_fifo.sv
// Synchronous FIFO for denomination codes; extra pointer bit
// separates full from empty.
module coin_fifo
  import vm_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  denom_code_t              i_data,
  output denom_code_t              o_data,
  output logic [$clog2(DEPTH):0]   o_level,
  output logic                     o_full,
  output logic                     o_empty
);

  localparam int AW = $clog2(DEPTH);

  denom_code_t       mem_q [DEPTH];
  logic [AW:0]       wp_q, wp_d;
  logic [AW:0]       rp_q, rp_d;
  logic              do_push;
  logic              do_pop;

  assign o_level = wp_q - rp_q;
  assign o_full  = (o_level == (AW+1)'(DEPTH));
  assign o_empty = (wp_q == rp_q);
  assign o_data  = mem_q[rp_q[AW-1:0]];

  assign do_push = i_push && !o_full;
  assign do_pop  = i_pop && !o_empty;

  always_comb begin
    wp_d = wp_q;
    rp_d = rp_q;
    if (do_push) wp_d = wp_q + 1'b1;
    if (do_pop)  rp_d = rp_q + 1'b1;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wp_q <= '0;
      rp_q <= '0;
    end else begin
      wp_q <= wp_d;
      rp_q <= rp_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (do_push) mem_q[wp_q[AW-1:0]] <= i_data;
  end

endmodule

// File: rtl/coin_acceptor.sv
// Coin validator: classify, buffer, pace money pulses, flush returns.
// Optional running total under COIN_ACCEPTOR_TOTAL_EN.
module coin_acceptor
  import vm_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int GAP_CYCLES = 2
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic [16:0]                   i_coin_value,
  input  logic                          i_coin_strobe,
  input  logic                          i_accept_en,
  input  logic                          i_flush,
`ifdef COIN_ACCEPTOR_TOTAL_EN
  input  logic                          i_total_clr,
  output logic [20:0]                   o_total,
`endif
  output logic [3:0]                    o_money,
  output logic                          o_money_valid,
  output logic                          o_coin_reject,
  output logic [3:0]                    o_return_code,
  output logic                          o_return_valid,
  output logic [$clog2(FIFO_DEPTH):0]   o_fifo_level,
  output logic                          o_fifo_empty,
  output logic                          o_fifo_full
);

  localparam int LW = $clog2(FIFO_DEPTH) + 1;
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GW-1:0] GAP_LAST =
    GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_GAP   = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [GW-1:0] gap_q, gap_d;
  denom_code_t   money_q, money_d;
  logic          mv_q, mv_d;
  denom_code_t   ret_q, ret_d;
  logic          rv_q, rv_d;
  logic          rej_q, rej_d;

  denom_code_t   code;
  denom_code_t   head;
  logic          push;
  logic          pop;
  logic [LW-1:0] level;
  logic          full;
  logic          empty;

  assign code = value_to_code(i_coin_value);
  // full is pre-edge, so a strobe while full loses even against a pop
  assign push = i_coin_strobe && (code != CODE_NONE)
             && !full && (state_q != S_FLUSH);
  assign rej_d = i_coin_strobe && !push;

  coin_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (push),
    .i_pop   (pop),
    .i_data  (code),
    .o_data  (head),
    .o_level (level),
    .o_full  (full),
    .o_empty (empty)
  );

  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    pop     = 1'b0;
    money_d = CODE_NONE;
    mv_d    = 1'b0;
    ret_d   = CODE_NONE;
    rv_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!empty) begin
          if (i_flush) begin
            state_d = S_FLUSH;
          end else if (i_accept_en) begin
            pop     = 1'b1;
            money_d = head;
            mv_d    = 1'b1;
            if (GAP_CYCLES > 0) begin
              state_d = S_GAP;
              gap_d   = '0;
            end
          end
        end
      end
      S_GAP: begin
        if (gap_q == GAP_LAST) begin
          state_d = S_IDLE;
          gap_d   = '0;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      S_FLUSH: begin
        if (empty) begin
          state_d = S_IDLE;
        end else begin
          pop   = 1'b1;
          ret_d = head;
          rv_d  = 1'b1;
          if (level == LW'(1)) state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      gap_q   <= '0;
      money_q <= CODE_NONE;
      mv_q    <= 1'b0;
      ret_q   <= CODE_NONE;
      rv_q    <= 1'b0;
      rej_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
      money_q <= money_d;
      mv_q    <= mv_d;
      ret_q   <= ret_d;
      rv_q    <= rv_d;
      rej_q   <= rej_d;
    end
  end

  assign o_money        = money_q;
  assign o_money_valid  = mv_q;
  assign o_return_code  = ret_q;
  assign o_return_valid = rv_q;
  assign o_coin_reject  = rej_q;
  assign o_fifo_level   = level;
  assign o_fifo_empty   = empty;
  assign o_fifo_full    = full;

`ifdef COIN_ACCEPTOR_TOTAL_EN
  logic [20:0] total_q;
  logic [21:0] sum;

  assign sum = {1'b0, total_q} + 22'(code_to_value(money_q));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      total_q <= '0;
    end else if (i_total_clr) begin
      total_q <= '0;
    end else if (mv_q) begin
      total_q <= sum[21] ? '1 : sum[20:0];
    end
  end

  assign o_total = total_q;
`endif

endmodule

// File: tb/tb_coin_acceptor.sv
// Bench for coin_acceptor: directed scenarios plus random traffic
// against a queue-based reference model.
module tb_coin_acceptor;

  localparam int D = 8;
  localparam int G = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [16:0] val = '0;
  logic        stb = 1'b0;
  logic        acc = 1'b0;
  logic        fl  = 1'b0;
  logic [3:0]  o_money;
  logic        o_money_valid;
  logic        o_coin_reject;
  logic [3:0]  o_return_code;
  logic        o_return_valid;
  logic [3:0]  o_fifo_level;
  logic        o_fifo_empty;
  logic        o_fifo_full;
`ifdef COIN_ACCEPTOR_TOTAL_EN
  logic        tclr = 1'b0;
  logic [20:0] o_total;
`endif

  always #5 clk = ~clk;

  coin_acceptor #(
    .FIFO_DEPTH (D),
    .GAP_CYCLES (G)
  ) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_coin_value   (val),
    .i_coin_strobe  (stb),
    .i_accept_en    (acc),
    .i_flush        (fl),
`ifdef COIN_ACCEPTOR_TOTAL_EN
    .i_total_clr    (tclr),
    .o_total        (o_total),
`endif
    .o_money        (o_money),
    .o_money_valid  (o_money_valid),
    .o_coin_reject  (o_coin_reject),
    .o_return_code  (o_return_code),
    .o_return_valid (o_return_valid),
    .o_fifo_level   (o_fifo_level),
    .o_fifo_empty   (o_fifo_empty),
    .o_fifo_full    (o_fifo_full)
  );

  typedef struct {
    int money; int mv; int rej;
    int ret; int rv; int level;
  } exp_t;

  exp_t cur, nxt;
  int   q[$];
  int   mode;
  int   gap_left;
  int   checks = 0;
  int   passes = 0;
  int   fails = 0;
  bit   chk_en = 1'b0;

  int vals[15] = '{50000, 20000, 10000, 5000, 2000, 1000, 500,
                   200, 100, 50, 25, 10, 5, 2, 1};
  int bad[6] = '{300, 0, 3, 49999, 100000, 131071};

  function automatic int code_of(int v);
    foreach (vals[i]) if (vals[i] == v) return i + 1;
    return 0;
  endfunction

  task automatic chk(string n, int act, int e);
    checks++;
    if (act != e) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", n, act, e, $time);
    end else begin
      passes++;
    end
  endtask

  function automatic exp_t zero_exp();
    exp_t e;
    e.money = 0; e.mv = 0; e.rej = 0;
    e.ret = 0; e.rv = 0; e.level = 0;
    return e;
  endfunction

  task automatic model_clear();
    q.delete();
    mode = 0;
    gap_left = 0;
    cur = zero_exp();
    nxt = zero_exp();
  endtask

  // mode: 0 waiting, 1 cooling down after a pulse, 2 returning coins
  task automatic model_step();
    exp_t e;
    int c;
    bit ok;
    e = zero_exp();
    c = stb ? code_of(int'(val)) : 0;
    ok = stb && c != 0 && q.size() < D && mode != 2;
    e.rej = (stb && !ok) ? 1 : 0;
    if (mode == 2) begin
      e.ret = q.pop_front();
      e.rv = 1;
      if (q.size() == 0) mode = 0;
    end else if (mode == 1) begin
      gap_left--;
      if (gap_left == 0) mode = 0;
    end else if (q.size() > 0 && fl) begin
      mode = 2;
    end else if (q.size() > 0 && acc) begin
      e.money = q.pop_front();
      e.mv = 1;
      if (G > 0) begin
        mode = 1;
        gap_left = G;
      end
    end
    if (ok) q.push_back(c);
    e.level = q.size();
    nxt = e;
  endtask

  task automatic cyc(bit s, int v, bit a, bit f);
    @(posedge clk);
    #1;
    cur = nxt;
    stb = s;
    val = 17'(v);
    acc = a;
    fl  = f;
    model_step();
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("money", int'(o_money), cur.money);
      chk("money_valid", int'(o_money_valid), cur.mv);
      chk("reject", int'(o_coin_reject), cur.rej);
      chk("return_code", int'(o_return_code), cur.ret);
      chk("return_valid", int'(o_return_valid), cur.rv);
      chk("level", int'(o_fifo_level), cur.level);
      chk("empty", int'(o_fifo_empty), cur.level == 0 ? 1 : 0);
      chk("full", int'(o_fifo_full), cur.level == D ? 1 : 0);
      if (o_money_valid && o_return_valid) chk("both_valid", 1, 0);
    end
  end

  task automatic do_reset();
    #2;
    rst = 1'b1;
    stb = 1'b0; acc = 1'b0; fl = 1'b0; val = '0;
    #1;
    chk("rst_money_valid", int'(o_money_valid), 0);
    chk("rst_money", int'(o_money), 0);
    chk("rst_return_valid", int'(o_return_valid), 0);
    chk("rst_reject", int'(o_coin_reject), 0);
    chk("rst_level", int'(o_fifo_level), 0);
    chk("rst_empty", int'(o_fifo_empty), 1);
    chk("rst_full", int'(o_fifo_full), 0);
    model_clear();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 2 * D + 4; i++) cyc(1'b0, 0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) cyc(1'b0, 0, 1'b0, 1'b0);
  endtask

  int codes[$];
  int times[$];
  int r;

  initial begin
    model_clear();
    do_reset();
    chk_en = 1'b1;

`ifdef COIN_ACCEPTOR_TOTAL_EN
    cyc(1'b1, 50000, 1'b1, 1'b0);
    cyc(1'b1, 25, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) cyc(1'b0, 0, 1'b1, 1'b0);
    chk("total_sum", int'(o_total), 50025);
    cyc(1'b1, 100, 1'b1, 1'b0);
    cyc(1'b0, 0, 1'b1, 1'b0);
    cyc(1'b0, 0, 1'b1, 1'b0);
    chk("total_pulse", int'(o_money_valid), 1);
    tclr = 1'b1;
    cyc(1'b0, 0, 1'b1, 1'b0);
    tclr = 1'b0;
    chk("total_clr", int'(o_total), 0);
    drain();
`endif

    // single coin latency
    cyc(1'b1, 100, 1'b1, 1'b0);
    cyc(1'b0, 0, 1'b1, 1'b0);
    chk("t1_n1_valid", int'(o_money_valid), 0);
    chk("t1_n1_level", int'(o_fifo_level), 1);
    cyc(1'b0, 0, 1'b1, 1'b0);
    chk("t1_n2_valid", int'(o_money_valid), 1);
    chk("t1_n2_money", int'(o_money), 9);
    chk("t1_n2_level", int'(o_fifo_level), 0);
    cyc(1'b0, 0, 1'b1, 1'b0);
    chk("t1_n3_valid", int'(o_money_valid), 0);
    drain();

    // paced forwarding
    cyc(1'b1, 500, 1'b0, 1'b0);
    cyc(1'b1, 25, 1'b0, 1'b0);
    cyc(1'b1, 1, 1'b0, 1'b0);
    cyc(1'b0, 0, 1'b0, 1'b0);
    chk("t2_level", int'(o_fifo_level), 3);
    codes.delete();
    times.delete();
    for (int i = 0; i < 16; i++) begin
      cyc(1'b0, 0, 1'b1, 1'b0);
      if (o_money_valid) begin
        codes.push_back(int'(o_money));
        times.push_back(i);
      end
    end
    chk("t2_count", codes.size(), 3);
    if (codes.size() == 3) begin
      chk("t2_code0", codes[0], 7);
      chk("t2_code1", codes[1], 11);
      chk("t2_code2", codes[2], 15);
      chk("t2_gap01", times[1] - times[0], 3);
      chk("t2_gap12", times[2] - times[1], 3);
    end
    drain();

    // rejects: invalid value and full FIFO
    cyc(1'b1, 300, 1'b0, 1'b0);
    cyc(1'b0, 0, 1'b0, 1'b0);
    chk("t3_reject_bad", int'(o_coin_reject), 1);
    chk("t3_level_bad", int'(o_fifo_level), 0);
    for (int i = 0; i < D; i++) cyc(1'b1, vals[i], 1'b0, 1'b0);
    cyc(1'b1, 5, 1'b0, 1'b0);
    cyc(1'b0, 0, 1'b0, 1'b0);
    chk("t3_reject_full", int'(o_coin_reject), 1);
    chk("t3_level_full", int'(o_fifo_level), 8);
    chk("t3_full", int'(o_fifo_full), 1);
    drain();

    // flush returns buffered coins
    cyc(1'b1, 5000, 1'b0, 1'b0);
    cyc(1'b1, 1000, 1'b0, 1'b0);
    cyc(1'b1, 200, 1'b0, 1'b0);
    cyc(1'b0, 0, 1'b0, 1'b1);
    cyc(1'b1, 100, 1'b0, 1'b0);
    codes.delete();
    for (int i = 0; i < 6; i++) begin
      cyc(1'b0, 0, 1'b0, 1'b0);
      if (i == 0) chk("t4_strobe_rej", int'(o_coin_reject), 1);
      if (o_return_valid) codes.push_back(int'(o_return_code));
      if (i == 0) chk("t4_rv_first", int'(o_return_valid), 1);
    end
    chk("t4_count", codes.size(), 3);
    if (codes.size() == 3) begin
      chk("t4_ret0", codes[0], 4);
      chk("t4_ret1", codes[1], 6);
      chk("t4_ret2", codes[2], 8);
    end
    chk("t4_level", int'(o_fifo_level), 0);
    drain();

    // reset during gap with coins buffered
    for (int i = 0; i < 6; i++) cyc(1'b1, vals[i + 3], 1'b0, 1'b0);
    cyc(1'b0, 0, 1'b1, 1'b0);
    cyc(1'b0, 0, 1'b0, 1'b0);
    chk("t5_pulse", int'(o_money_valid), 1);
    chk("t5_level", int'(o_fifo_level), 5);
    do_reset();
    for (int i = 0; i < 8; i++) begin
      cyc(1'b0, 0, 1'b1, 1'b0);
      if (o_money_valid) chk("t5_stale", 1, 0);
    end
    chk("t5_empty", int'(o_fifo_empty), 1);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 40) begin
        if ($urandom_range(0, 4) == 0)
          cyc(1'b1, bad[$urandom_range(0, 5)],
              1'($urandom_range(0, 1)), ($urandom_range(0, 19) == 0));
        else
          cyc(1'b1, vals[$urandom_range(0, 14)],
              1'($urandom_range(0, 1)), ($urandom_range(0, 19) == 0));
      end else begin
        cyc(1'b0, int'($urandom_range(0, 131071)),
            ($urandom_range(0, 2) == 0), ($urandom_range(0, 24) == 0));
      end
    end
    cyc(1'b0, 0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    cur = nxt;
    @(negedge clk);
    #1;
    chk_en = 1'b0;

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
